// File: rtl/ifm_s2mm_arb.sv
// Frame-granular two-way round-robin arbiter merging two IFM status/data stream
// pairs onto one S2MM DMA. A whole frame (status, then data) from the granted
// port is forwarded before the other port may be switched in. A stalled data
// phase is closed with an empty tlast beat after C_TIMEOUT idle source cycles.
// Build option: define IFM_ARB_STATS_EN to implement the per-port frame counters;
// otherwise frm_cnt0/frm_cnt1 read as zero and no counter registers exist.
module ifm_s2mm_arb #(
  parameter int unsigned C_TIMEOUT = 1024
) (
  input  logic        s2mm_clk,
  input  logic        s2mm_resetn,
  input  logic [31:0] rxs0_tdata,
  input  logic [3:0]  rxs0_tkeep,
  input  logic        rxs0_tlast,
  input  logic        rxs0_tvalid,
  output logic        rxs0_tready,
  input  logic [31:0] rxs1_tdata,
  input  logic [3:0]  rxs1_tkeep,
  input  logic        rxs1_tlast,
  input  logic        rxs1_tvalid,
  output logic        rxs1_tready,
  input  logic [63:0] rxd0_tdata,
  input  logic [7:0]  rxd0_tkeep,
  input  logic        rxd0_tlast,
  input  logic        rxd0_tvalid,
  output logic        rxd0_tready,
  input  logic [63:0] rxd1_tdata,
  input  logic [7:0]  rxd1_tkeep,
  input  logic        rxd1_tlast,
  input  logic        rxd1_tvalid,
  output logic        rxd1_tready,
  output logic [31:0] rxs_tdata,
  output logic [3:0]  rxs_tkeep,
  output logic        rxs_tlast,
  output logic        rxs_tvalid,
  input  logic        rxs_tready,
  output logic [63:0] rxd_tdata,
  output logic [7:0]  rxd_tkeep,
  output logic        rxd_tlast,
  output logic        rxd_tvalid,
  input  logic        rxd_tready,
  output logic [3:0]  arb_fsm_dbg,
  output logic [31:0] frm_cnt0,
  output logic [31:0] frm_cnt1
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StSts   = 2'd1,
    StDat   = 2'd2,
    StFlush = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic        grant_q, grant_d;
  logic        last_grant_q, last_grant_d;
  logic        trunc_q, trunc_d;
  logic [31:0] tmo_cnt_q, tmo_cnt_d;

  // Granted-port views of the source streams
  logic [31:0] gs_tdata;
  logic [3:0]  gs_tkeep;
  logic        gs_tlast, gs_tvalid;
  logic [63:0] gd_tdata;
  logic [7:0]  gd_tkeep;
  logic        gd_tlast, gd_tvalid;

  assign gs_tdata  = grant_q ? rxs1_tdata  : rxs0_tdata;
  assign gs_tkeep  = grant_q ? rxs1_tkeep  : rxs0_tkeep;
  assign gs_tlast  = grant_q ? rxs1_tlast  : rxs0_tlast;
  assign gs_tvalid = grant_q ? rxs1_tvalid : rxs0_tvalid;
  assign gd_tdata  = grant_q ? rxd1_tdata  : rxd0_tdata;
  assign gd_tkeep  = grant_q ? rxd1_tkeep  : rxd0_tkeep;
  assign gd_tlast  = grant_q ? rxd1_tlast  : rxd0_tlast;
  assign gd_tvalid = grant_q ? rxd1_tvalid : rxd0_tvalid;

  // Output steering: zero-latency pass-through of the granted port per phase
  always_comb begin
    rxs_tdata   = '0;
    rxs_tkeep   = '0;
    rxs_tlast   = 1'b0;
    rxs_tvalid  = 1'b0;
    rxd_tdata   = '0;
    rxd_tkeep   = '0;
    rxd_tlast   = 1'b0;
    rxd_tvalid  = 1'b0;
    rxs0_tready = 1'b0;
    rxs1_tready = 1'b0;
    rxd0_tready = 1'b0;
    rxd1_tready = 1'b0;
    case (state_q)
      StSts: begin
        rxs_tvalid = gs_tvalid;
        if (gs_tvalid) begin
          rxs_tdata = gs_tdata;
          rxs_tkeep = gs_tkeep;
          rxs_tlast = gs_tlast;
        end
        rxs0_tready = ~grant_q & rxs_tready;
        rxs1_tready = grant_q & rxs_tready;
      end
      StDat: begin
        rxd_tvalid = gd_tvalid;
        if (gd_tvalid) begin
          rxd_tdata = gd_tdata;
          rxd_tkeep = gd_tkeep;
          rxd_tlast = gd_tlast;
        end
        rxd0_tready = ~grant_q & rxd_tready;
        rxd1_tready = grant_q & rxd_tready;
      end
      StFlush: begin
        // Synthetic empty closing beat; sources are not consumed
        rxd_tvalid = 1'b1;
        rxd_tlast  = 1'b1;
      end
      default: ;
    endcase
  end

  // Next-state: arbitration, phase sequencing and data-phase stall timeout
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    trunc_d      = trunc_q;
    tmo_cnt_d    = tmo_cnt_q;
    case (state_q)
      StIdle: begin
        if (rxs0_tvalid | rxs1_tvalid) begin
          grant_d = (rxs0_tvalid & rxs1_tvalid) ? ~last_grant_q : rxs1_tvalid;
          state_d = StSts;
        end
      end
      StSts: begin
        if (rxs_tvalid & rxs_tready & rxs_tlast) begin
          state_d   = StDat;
          tmo_cnt_d = '0;
        end
      end
      StDat: begin
        if (rxd_tvalid & rxd_tready & rxd_tlast) begin
          state_d      = StIdle;
          last_grant_d = grant_q;
        end else if (C_TIMEOUT != 0) begin
          if (gd_tvalid) begin
            tmo_cnt_d = '0;
          end else begin
            tmo_cnt_d = tmo_cnt_q + 32'd1;
            if (tmo_cnt_q == 32'(C_TIMEOUT - 1)) state_d = StFlush;
          end
        end
      end
      StFlush: begin
        if (rxd_tready) begin
          state_d      = StIdle;
          trunc_d      = 1'b1;
          last_grant_d = grant_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset abandons any frame in flight
  always_ff @(posedge s2mm_clk or negedge s2mm_resetn) begin
    if (!s2mm_resetn) begin
      state_q      <= StIdle;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      trunc_q      <= 1'b0;
      tmo_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      trunc_q      <= trunc_d;
      tmo_cnt_q    <= tmo_cnt_d;
    end
  end

  assign arb_fsm_dbg = {trunc_q, grant_q, state_q};

`ifdef IFM_ARB_STATS_EN
  logic        frm_done;
  logic [31:0] frm_cnt0_q, frm_cnt1_q;

  // Flush-terminated frames are not counted
  assign frm_done = (state_q == StDat) & rxd_tvalid & rxd_tready & rxd_tlast;

  // Per-port completed-frame counters, wrapping
  always_ff @(posedge s2mm_clk or negedge s2mm_resetn) begin
    if (!s2mm_resetn) begin
      frm_cnt0_q <= '0;
      frm_cnt1_q <= '0;
    end else if (frm_done) begin
      if (grant_q) frm_cnt1_q <= frm_cnt1_q + 32'd1;
      else         frm_cnt0_q <= frm_cnt0_q + 32'd1;
    end
  end

  assign frm_cnt0 = frm_cnt0_q;
  assign frm_cnt1 = frm_cnt1_q;
`else
  assign frm_cnt0 = '0;
  assign frm_cnt1 = '0;
`endif

endmodule

// File: tb/tb_ifm_s2mm_arb.sv
// Directed bench for ifm_s2mm_arb: single frame, tie alternation, backpressure,
// data-phase timeout flush and mid-frame reset.
module tb_ifm_s2mm_arb;

  localparam int unsigned Tmo = 16;
`ifdef IFM_ARB_STATS_EN
  localparam bit StatsEn = 1'b1;
`else
  localparam bit StatsEn = 1'b0;
`endif

  logic        s2mm_clk = 1'b0;
  logic        s2mm_resetn;
  logic [31:0] rxs0_tdata, rxs1_tdata, rxs_tdata;
  logic [3:0]  rxs0_tkeep, rxs1_tkeep, rxs_tkeep;
  logic        rxs0_tlast, rxs1_tlast, rxs_tlast;
  logic        rxs0_tvalid, rxs1_tvalid, rxs_tvalid;
  logic        rxs0_tready, rxs1_tready, rxs_tready;
  logic [63:0] rxd0_tdata, rxd1_tdata, rxd_tdata;
  logic [7:0]  rxd0_tkeep, rxd1_tkeep, rxd_tkeep;
  logic        rxd0_tlast, rxd1_tlast, rxd_tlast;
  logic        rxd0_tvalid, rxd1_tvalid, rxd_tvalid;
  logic        rxd0_tready, rxd1_tready, rxd_tready;
  logic [3:0]  arb_fsm_dbg;
  logic [31:0] frm_cnt0, frm_cnt1;

  int n_chk = 0;
  int n_err = 0;
  int exp_cnt0 = 0;
  int exp_cnt1 = 0;

  always #5 s2mm_clk = ~s2mm_clk;

  ifm_s2mm_arb #(.C_TIMEOUT(Tmo)) dut (
    .s2mm_clk(s2mm_clk), .s2mm_resetn(s2mm_resetn),
    .rxs0_tdata(rxs0_tdata), .rxs0_tkeep(rxs0_tkeep), .rxs0_tlast(rxs0_tlast),
    .rxs0_tvalid(rxs0_tvalid), .rxs0_tready(rxs0_tready),
    .rxs1_tdata(rxs1_tdata), .rxs1_tkeep(rxs1_tkeep), .rxs1_tlast(rxs1_tlast),
    .rxs1_tvalid(rxs1_tvalid), .rxs1_tready(rxs1_tready),
    .rxd0_tdata(rxd0_tdata), .rxd0_tkeep(rxd0_tkeep), .rxd0_tlast(rxd0_tlast),
    .rxd0_tvalid(rxd0_tvalid), .rxd0_tready(rxd0_tready),
    .rxd1_tdata(rxd1_tdata), .rxd1_tkeep(rxd1_tkeep), .rxd1_tlast(rxd1_tlast),
    .rxd1_tvalid(rxd1_tvalid), .rxd1_tready(rxd1_tready),
    .rxs_tdata(rxs_tdata), .rxs_tkeep(rxs_tkeep), .rxs_tlast(rxs_tlast),
    .rxs_tvalid(rxs_tvalid), .rxs_tready(rxs_tready),
    .rxd_tdata(rxd_tdata), .rxd_tkeep(rxd_tkeep), .rxd_tlast(rxd_tlast),
    .rxd_tvalid(rxd_tvalid), .rxd_tready(rxd_tready),
    .arb_fsm_dbg(arb_fsm_dbg), .frm_cnt0(frm_cnt0), .frm_cnt1(frm_cnt1)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_frm(input int c);
    return StatsEn ? 32'(c) : 32'd0;
  endfunction

  function automatic logic [31:0] sts_word(input int p);
    return 32'h40 + 32'(p) * 32'h100;
  endfunction

  task automatic set_s(input int p, input logic v, input logic [31:0] d);
    if (p == 0) begin
      rxs0_tvalid = v; rxs0_tdata = d; rxs0_tkeep = 4'hF; rxs0_tlast = 1'b1;
    end else begin
      rxs1_tvalid = v; rxs1_tdata = d; rxs1_tkeep = 4'hF; rxs1_tlast = 1'b1;
    end
  endtask

  task automatic set_d(input int p, input logic v, input logic [63:0] d, input logic [7:0] k,
                       input logic l);
    if (p == 0) begin
      rxd0_tvalid = v; rxd0_tdata = d; rxd0_tkeep = k; rxd0_tlast = l;
    end else begin
      rxd1_tvalid = v; rxd1_tdata = d; rxd1_tkeep = k; rxd1_tlast = l;
    end
  endtask

  function automatic logic other_rdy(input int p);
    return (p == 0) ? (rxs1_tready | rxd1_tready) : (rxs0_tready | rxd0_tready);
  endfunction

  function automatic logic s_rdy(input int p);
    return (p == 0) ? rxs0_tready : rxs1_tready;
  endfunction

  function automatic logic d_rdy(input int p);
    return (p == 0) ? rxd0_tready : rxd1_tready;
  endfunction

  task automatic pulse_reset();
    @(posedge s2mm_clk); #1;
    s2mm_resetn = 1'b0;
    exp_cnt0 = 0;
    exp_cnt1 = 0;
    @(posedge s2mm_clk); #1;
    s2mm_resetn = 1'b1;
  endtask

  // ev_kind: 0 none, 1 source stalls before data beat ev_at (expect flush),
  //          2 reset after ev_at data beats
  task automatic run_frame(input int p, input int nb, input logic [7:0] lkeep, input bit toggle,
                           input int ev_at, input int ev_kind, input bit rearm);
    int n;
    bit hs;
    logic [63:0] dv;
    logic [7:0] kv;
    set_s(p, 1'b1, sts_word(p));
    n = 0;
    hs = 1'b0;
    while (!hs && n < 100) begin
      @(negedge s2mm_clk);
      n++;
      check_eq("other_rdy_sts", other_rdy(p), 0);
      hs = s_rdy(p);
    end
    check_eq("sts_wait", hs, 1);
    if (!hs) return;
    check_eq("grant", arb_fsm_dbg[2], p);
    check_eq("rxs_tvalid", rxs_tvalid, 1);
    check_eq("rxs_tdata", rxs_tdata, sts_word(p));
    check_eq("rxs_tlast", {rxs_tkeep, rxs_tlast}, 5'h1F);
    check_eq("sts_no_dat", {rxd_tvalid, rxd0_tready, rxd1_tready}, 0);
    @(posedge s2mm_clk); #1;
    set_s(p, 1'b0, 32'd0);

    for (int b = 0; b < nb; b++) begin
      if (ev_kind == 1 && b == ev_at) begin
        set_d(p, 1'b0, 64'd0, 8'd0, 1'b0);
        n = 0;
        @(negedge s2mm_clk);
        while (!rxd_tvalid && n < 40) begin
          n++;
          @(negedge s2mm_clk);
        end
        check_eq("stall_cycles", n, Tmo);
        check_eq("flush_beat", {rxd_tvalid, rxd_tlast, rxd_tkeep}, 10'h300);
        check_eq("flush_data", rxd_tdata, 0);
        check_eq("flush_state", {arb_fsm_dbg[1:0], d_rdy(p), other_rdy(p)}, 4'hC);
        @(posedge s2mm_clk); #1;
        @(negedge s2mm_clk);
        check_eq("trunc_idle", {arb_fsm_dbg[3], arb_fsm_dbg[1:0]}, 3'b100);
        check_eq("flush_nocnt", {frm_cnt0, frm_cnt1}, {exp_frm(exp_cnt0), exp_frm(exp_cnt1)});
        return;
      end
      dv = {8'(p), 24'h0, 32'(b)};
      kv = (b == nb - 1) ? lkeep : 8'hFF;
      set_d(p, 1'b1, dv, kv, b == nb - 1);
      hs = 1'b0;
      n = 0;
      while (!hs && n < 100) begin
        @(negedge s2mm_clk);
        n++;
        check_eq("other_rdy_dat", other_rdy(p), 0);
        check_eq("rdy_follow", d_rdy(p), rxd_tready);
        check_eq("rxs_quiet", rxs_tvalid, 0);
        hs = rxd_tready;
        if (hs) begin
          check_eq("rxd_tvalid", rxd_tvalid, 1);
          check_eq("rxd_tdata", rxd_tdata, dv);
          check_eq("rxd_tkeep", rxd_tkeep, kv);
          check_eq("rxd_tlast", rxd_tlast, b == nb - 1);
        end
        @(posedge s2mm_clk); #1;
        if (toggle) rxd_tready = ~rxd_tready;
      end
      check_eq("dat_wait", hs, 1);
      if (!hs) return;
      if (ev_kind == 2 && b + 1 == ev_at) begin
        s2mm_resetn = 1'b0;
        exp_cnt0 = 0;
        exp_cnt1 = 0;
        #1;
        check_eq("rst_valid", {rxs_tvalid, rxd_tvalid}, 0);
        check_eq("rst_ready", {rxs0_tready, rxs1_tready, rxd0_tready, rxd1_tready}, 0);
        check_eq("rst_data", rxd_tdata, 0);
        check_eq("rst_cnt", {frm_cnt0, frm_cnt1}, 0);
        check_eq("rst_dbg", arb_fsm_dbg, 0);
        set_d(p, 1'b0, 64'd0, 8'd0, 1'b0);
        @(posedge s2mm_clk); #1;
        s2mm_resetn = 1'b1;
        return;
      end
    end
    set_d(p, 1'b0, 64'd0, 8'd0, 1'b0);
    if (rearm) set_s(p, 1'b1, sts_word(p));
    rxd_tready = 1'b1;
    if (p == 0) exp_cnt0++;
    else exp_cnt1++;
    @(negedge s2mm_clk);
    check_eq("idle_gap", arb_fsm_dbg[1:0], 0);
    check_eq("frm_cnt0", frm_cnt0, exp_frm(exp_cnt0));
    check_eq("frm_cnt1", frm_cnt1, exp_frm(exp_cnt1));
  endtask

  initial begin
    s2mm_resetn = 1'b0;
    set_s(0, 1'b0, 32'd0);
    set_s(1, 1'b0, 32'd0);
    set_d(0, 1'b0, 64'd0, 8'd0, 1'b0);
    set_d(1, 1'b0, 64'd0, 8'd0, 1'b0);
    rxs_tready = 1'b1;
    rxd_tready = 1'b1;

    // Reset state, with a source already requesting
    #2;
    set_s(0, 1'b1, 32'h1234_5678);
    set_d(0, 1'b1, 64'hDEAD_BEEF_0000_0001, 8'hFF, 1'b0);
    repeat (3) @(negedge s2mm_clk);
    check_eq("rst_valid", {rxs_tvalid, rxd_tvalid}, 0);
    check_eq("rst_ready", {rxs0_tready, rxs1_tready, rxd0_tready, rxd1_tready}, 0);
    check_eq("rst_data", {rxs_tdata, rxd_tdata[31:0]}, 0);
    check_eq("rst_dbg", arb_fsm_dbg, 0);
    check_eq("rst_cnt", {frm_cnt0, frm_cnt1}, 0);
    set_s(0, 1'b0, 32'd0);
    set_d(0, 1'b0, 64'd0, 8'd0, 1'b0);
    @(posedge s2mm_clk); #1;
    s2mm_resetn = 1'b1;

    // Single frame from port 0, last keep 0x0F
    run_frame(0, 8, 8'h0F, 1'b0, -1, 0, 1'b0);

    // Tie after reset: port 0 first, then strict alternation
    pulse_reset();
    set_s(0, 1'b1, sts_word(0));
    set_s(1, 1'b1, sts_word(1));
    run_frame(0, 3, 8'hFF, 1'b0, -1, 0, 1'b1);
    run_frame(1, 3, 8'h3F, 1'b0, -1, 0, 1'b1);
    run_frame(0, 2, 8'h01, 1'b0, -1, 0, 1'b0);
    run_frame(1, 4, 8'hFF, 1'b0, -1, 0, 1'b0);

    // Backpressure: DMA tready toggles every cycle
    run_frame(0, 8, 8'hFF, 1'b1, -1, 0, 1'b0);

    // Port 1 stalls after 3 data beats -> flush; port 0 served next
    run_frame(1, 8, 8'hFF, 1'b0, 3, 1, 1'b0);
    run_frame(0, 2, 8'h07, 1'b0, -1, 0, 1'b0);

    // Reset after 2 data beats, then a clean frame
    run_frame(0, 8, 8'hFF, 1'b0, 2, 2, 1'b0);
    run_frame(0, 3, 8'h03, 1'b0, -1, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
